duty_meas_scheduler: RTL and testbench

//  Time-shares one duty_cycle_meter across NUM_CH analog inputs behind a front-end ADC mux.
//  Per channel: select mux, hold meter in reset while the input settles, release it,

---
 rtl/duty_sched_pkg.sv | 26 ++
 rtl/duty_meas_timer.sv | 38 +++
 rtl/duty_meas_scheduler.sv | 151 +++++++++++++++
 tb/tb_duty_meas_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_sched_pkg.sv
// Shared state, status and range constants for the duty-cycle measurement scheduler.
package duty_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_RES = 2'd2,
    PUBLISH  = 2'd3
  } sched_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_RANGE   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [15:0] DUTY_MIN_DEF = 16'd2000;
  localparam logic [15:0] DUTY_MAX_DEF = 16'd8000;

  localparam int TMR_W = 25;

  function automatic logic [1:0] duty_status(input logic [15:0] duty,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
    return (duty < lo || duty > hi) ? ST_RANGE : ST_OK;
  endfunction

endpackage

// File: rtl/duty_meas_timer.sv
// Saturating clear/enable cycle counter with a terminal-count flag.
// Shared by the settle and result-wait phases of the scheduler.
module duty_meas_timer
  import duty_sched_pkg::*;
(
  input  logic             clk_10m,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMR_W-1:0] term_i,
  output logic             tc_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // NOTE: default assignment first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != '1) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk_10m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == term_i);

endmodule

// File: rtl/duty_meas_scheduler.sv
// Time-shares one duty_cycle_meter across NUM_CH mux inputs and publishes one
// tagged record per channel to a ready/valid consumer.
module duty_meas_scheduler
  import duty_sched_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CH_W        = 2,
  parameter int          SETTLE_CYC  = 100,
  parameter int          TIMEOUT_CYC = 30_000_000,
  parameter logic [15:0] DUTY_MIN    = DUTY_MIN_DEF,
  parameter logic [15:0] DUTY_MAX    = DUTY_MAX_DEF
) (
  input  logic            clk_10m,
  input  logic            rst,
  input  logic            start,
  input  logic            cont,
  input  logic            abort,
  output logic            meter_rst,
  output logic [CH_W-1:0] ch_sel,
  input  logic            duty_valid,
  input  logic [15:0]     duty_cycle,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CH_W-1:0] res_ch,
  output logic [15:0]     res_duty,
  output logic [1:0]      res_status,
  output logic            busy,
  output logic            round_done
);

  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] SETTLE_TERM  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_TERM = TMR_W'(TIMEOUT_CYC - 1);

  sched_state_e    state_q;
  logic            meter_rst_q;
  logic [CH_W-1:0] ch_sel_q;
  logic            res_valid_q;
  logic [CH_W-1:0] res_ch_q;
  logic [15:0]     res_duty_q;
  logic [1:0]      res_status_q;
  logic            busy_q;
  logic            round_done_q;
  logic            dv_dly_q;

  logic             tmr_en;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [TMR_W-1:0] tmr_term;
  logic             dv_rise;

  // Counter runs only in SETTLE/WAIT_RES and restarts at zero on every phase entry.
  assign tmr_en   = (state_q == SETTLE) || (state_q == WAIT_RES);
  assign tmr_clr  = !tmr_en || tmr_tc;
  assign tmr_term = (state_q == SETTLE) ? SETTLE_TERM : TIMEOUT_TERM;

  // A valid level already high when WAIT_RES is entered is stale, not a new result.
  assign dv_rise = duty_valid & ~dv_dly_q;

  duty_meas_timer u_timer (
    .clk_10m (clk_10m),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .term_i  (tmr_term),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk_10m or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      meter_rst_q  <= 1'b1;
      ch_sel_q     <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_duty_q   <= '0;
      res_status_q <= ST_OK;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      dv_dly_q     <= 1'b0;
    end else begin
      dv_dly_q     <= duty_valid;
      round_done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
        meter_rst_q <= 1'b1;
        ch_sel_q    <= '0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              ch_sel_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= SETTLE;
            end
          end
          SETTLE: begin
            if (tmr_tc) begin
              meter_rst_q <= 1'b0;
              state_q     <= WAIT_RES;
            end
          end
          WAIT_RES: begin
            if (dv_rise || tmr_tc) begin
              if (dv_rise) begin
                res_duty_q   <= duty_cycle;
                res_status_q <= duty_status(duty_cycle, DUTY_MIN, DUTY_MAX);
              end else begin
                res_duty_q   <= '0;
                res_status_q <= ST_TIMEOUT;
              end
              res_ch_q    <= ch_sel_q;
              res_valid_q <= 1'b1;
              meter_rst_q <= 1'b1;
              state_q     <= PUBLISH;
            end
          end
          PUBLISH: begin
            if (res_valid_q && res_ready) begin
              res_valid_q <= 1'b0;
              if (ch_sel_q != LAST_CH) begin
                ch_sel_q <= ch_sel_q + CH_W'(1);
                state_q  <= SETTLE;
              end else if (cont) begin
                ch_sel_q <= '0;
                state_q  <= SETTLE;
              end else begin
                round_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign meter_rst  = meter_rst_q;
  assign ch_sel     = ch_sel_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_duty   = res_duty_q;
  assign res_status = res_status_q;
  assign busy       = busy_q;
  assign round_done = round_done_q;

endmodule

// File: tb/tb_duty_meas_scheduler.sv
// Randomized bench for duty_meas_scheduler with a behavioural meter and record model.
module tb_duty_meas_scheduler;

  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int SETTLE_CYC  = 10;
  localparam int TIMEOUT_CYC = 1000;
  localparam int STRETCH     = 20;
  localparam int FORCE_LEN   = 50;
  localparam int WAIT_MAX    = 3000;

  logic            clk_10m = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            cont = 1'b0;
  logic            abort = 1'b0;
  logic            res_ready = 1'b0;
  logic            duty_valid;
  logic [15:0]     duty_cycle;
  logic            meter_rst, res_valid, busy, round_done;
  logic [CH_W-1:0] ch_sel, res_ch;
  logic [15:0]     res_duty;
  logic [1:0]      res_status;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_chg = 0;
  int t_fall = 0;
  int low_cnt = 0;

  int          m_delay [NUM_CH];
  logic [15:0] m_val   [NUM_CH];
  bit          m_silent[NUM_CH];
  bit          force_dv = 1'b0;

  duty_meas_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_10m(clk_10m), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .meter_rst(meter_rst), .ch_sel(ch_sel), .duty_valid(duty_valid), .duty_cycle(duty_cycle),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_duty(res_duty),
    .res_status(res_status), .busy(busy), .round_done(round_done)
  );

  always #50 clk_10m = ~clk_10m;
  always @(posedge clk_10m) cyc <= cyc + 1;

  // Meter model: silent while held in reset, then valid for STRETCH cycles after m_delay cycles.
  initial begin
    duty_valid = 1'b0;
    duty_cycle = 16'd0;
    forever begin
      @(negedge clk_10m);
      low_cnt = meter_rst ? 0 : low_cnt + 1;
      if (force_dv && (meter_rst || low_cnt < FORCE_LEN)) begin
        duty_valid = 1'b1;
        duty_cycle = 16'd1234;
      end else begin
        duty_valid = !meter_rst && !m_silent[ch_sel] && low_cnt >= m_delay[ch_sel]
                     && low_cnt < m_delay[ch_sel] + STRETCH;
        duty_cycle = m_val[ch_sel];
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // Expected record for channel c from the meter setup alone.
  function automatic void expect_rec(input int c, output logic [15:0] duty,
                                     output logic [1:0] st, output int lat);
    if (m_silent[c] || m_delay[c] > TIMEOUT_CYC) begin
      duty = 16'd0; st = 2'b10; lat = TIMEOUT_CYC;
    end else begin
      duty = m_val[c];
      st   = (m_val[c] < 16'd2000 || m_val[c] > 16'd8000) ? 2'b01 : 2'b00;
      lat  = m_delay[c];
    end
  endfunction

  task automatic tick();
    @(negedge clk_10m);
  endtask

  task automatic set_ch(input int c, input logic [15:0] val, input int dly, input bit silent);
    m_val[c] = val; m_delay[c] = dly; m_silent[c] = silent;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t_chg = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_busy: busy=%b want 1", busy);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, res_valid, meter_rst, ch_sel, round_done} !== {1'b0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: busy=%b res_valid=%b meter_rst=%b ch_sel=%0d round_done=%b want 0 0 1 0 0",
               busy, res_valid, meter_rst, ch_sel, round_done);
    end
  endtask

  task automatic wait_rst_low(input int c, output bit ok);
    int n = 0;
    while (meter_rst === 1'b1 && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (meter_rst !== 1'b0) begin
      errors++; ok = 1'b0;
      $display("FAIL settle_wait ch%0d: meter_rst=%b after %0d cycles want 0", c, meter_rst, n);
      return;
    end
    ok = 1'b1;
    t_fall = cyc;
    checks++;
    if (cyc - t_chg != SETTLE_CYC) begin
      errors++; $display("FAIL settle_len ch%0d: got %0d cycles want %0d", c, cyc - t_chg, SETTLE_CYC);
    end
    checks++;
    if (ch_sel !== CH_W'(c)) begin
      errors++; $display("FAIL ch_sel: got %0d want %0d", ch_sel, c);
    end
  endtask

  task automatic wait_valid(input int c, output bit ok);
    int n = 0;
    logic [15:0] ed; logic [1:0] es; int el;
    while (res_valid !== 1'b1 && n < WAIT_MAX) begin tick(); n++; end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; ok = 1'b0;
      $display("FAIL result_wait ch%0d: res_valid=%b after %0d cycles want 1", c, res_valid, n);
      return;
    end
    ok = 1'b1;
    expect_rec(c, ed, es, el);
    checks++;
    if (cyc - t_fall != el) begin
      errors++; $display("FAIL latency ch%0d: got %0d want %0d", c, cyc - t_fall, el);
    end
    checks++;
    if ({res_ch, res_duty, res_status, meter_rst} !== {CH_W'(c), ed, es, 1'b1}) begin
      errors++;
      $display("FAIL record ch%0d: ch=%0d duty=%0d status=%b meter_rst=%b want ch=%0d duty=%0d status=%b meter_rst=1",
               c, res_ch, res_duty, res_status, meter_rst, c, ed, es);
    end
  endtask

  task automatic accept(input int c, input int stall);
    logic [15:0] ed; logic [1:0] es; int el;
    bit stable = 1'b1;
    expect_rec(c, ed, es, el);
    for (int i = 0; i < stall; i++) begin
      tick();
      if ({res_valid, res_ch, res_duty, res_status, meter_rst, ch_sel} !==
          {1'b1, CH_W'(c), ed, es, 1'b1, CH_W'(c)}) stable = 1'b0;
    end
    if (stall > 0) begin
      checks++;
      if (!stable) begin
        errors++; $display("FAIL hold ch%0d: record/meter_rst/ch_sel changed during %0d-cycle stall, want stable", c, stall);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL accept_clear ch%0d: res_valid=%b want 0", c, res_valid);
    end
    if (c == NUM_CH - 1 && !cont) begin
      checks++;
      if ({round_done, busy} !== 2'b10) begin
        errors++; $display("FAIL round_done: round_done=%b busy=%b want 1 0", round_done, busy);
      end
      tick();
      checks++;
      if (round_done !== 1'b0) begin
        errors++; $display("FAIL round_done_pulse: round_done=%b want 0", round_done);
      end
    end else begin
      t_chg = cyc;
      checks++;
      if ({round_done, busy, ch_sel} !== {1'b0, 1'b1, CH_W'((c + 1) % NUM_CH)}) begin
        errors++;
        $display("FAIL advance ch%0d: round_done=%b busy=%b ch_sel=%0d want 0 1 %0d",
                 c, round_done, busy, ch_sel, (c + 1) % NUM_CH);
      end
    end
  endtask

  task automatic do_round(input int n_rec, input int stall_ch, input int stall_len);
    bit ok = 1'b1;
    pulse_start();
    for (int r = 0; r < n_rec; r++) begin
      int c = r % NUM_CH;
      wait_rst_low(c, ok);
      if (!ok) break;
      wait_valid(c, ok);
      if (!ok) break;
      accept(c, (c == stall_ch) ? stall_len : int'($urandom_range(0, 3)));
    end
    if (!ok) do_abort();
  endtask

  task automatic rand_delays(input int lo, input int hi);
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 16'($urandom_range(2000, 8000)), $urandom_range(lo, hi), 1'b0);
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({meter_rst, ch_sel, res_valid, res_ch, res_duty, res_status, busy, round_done} !==
        {1'b1, 2'b00, 1'b0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: meter_rst=%b ch_sel=%0d res_valid=%b res_ch=%0d duty=%0d status=%b busy=%b round_done=%b want 1 0 0 0 0 00 0 0",
               meter_rst, ch_sel, res_valid, res_ch, res_duty, res_status, busy, round_done);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, meter_rst} !== 2'b01) begin
      errors++; $display("FAIL idle_after_reset: busy=%b meter_rst=%b want 0 1", busy, meter_rst);
    end
  endtask

  task automatic test_basic();
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 16'd5000, $urandom_range(1, 200), 1'b0);
    do_round(NUM_CH, -1, 0);
  endtask

  task automatic test_range();
    set_ch(0, 16'd5000, 5, 1'b0); set_ch(1, 16'd1500, 30, 1'b0);
    set_ch(2, 16'd8001, 7, 1'b0); set_ch(3, 16'd2000, 1, 1'b0);
    do_round(NUM_CH, -1, 0);
    set_ch(0, 16'd8000, 9, 1'b0); set_ch(1, 16'd1999, 12, 1'b0);
    set_ch(2, 16'd0, 3, 1'b0);    set_ch(3, 16'hFFFF, 40, 1'b0);
    do_round(NUM_CH, -1, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        logic [15:0] v;
        case ($urandom_range(0, 2))
          0: v = 16'($urandom);
          1: v = 16'(2000 + int'($urandom_range(0, 2)) - 1);
          default: v = 16'(8000 + int'($urandom_range(0, 2)) - 1);
        endcase
        set_ch(c, v, $urandom_range(1, 150), 1'b0);
      end
      do_round(NUM_CH, -1, 0);
    end
  endtask

  task automatic test_timeout();
    rand_delays(1, 200);
    m_silent[2] = 1'b1;
    do_round(NUM_CH, -1, 0);
    set_ch(0, 16'd3000, TIMEOUT_CYC - 1, 1'b0);
    set_ch(1, 16'd7000, TIMEOUT_CYC, 1'b0);
    set_ch(2, 16'd4000, TIMEOUT_CYC + 1, 1'b0);
    set_ch(3, 16'd5000, 10, 1'b1);
    do_round(NUM_CH, -1, 0);
  endtask

  task automatic test_backpressure();
    rand_delays(1, 100);
    do_round(NUM_CH, 1, 500);
  endtask

  task automatic test_entry_high();
    rand_delays(FORCE_LEN + 10, 200);
    force_dv = 1'b1;
    do_round(NUM_CH, -1, 0);
    force_dv = 1'b0;
  endtask

  task automatic test_cont_wrap();
    rand_delays(1, 100);
    cont = 1'b1;
    do_round(NUM_CH + 2, -1, 0);
    cont = 1'b0;
    do_abort();
  endtask

  task automatic test_abort();
    bit ok;
    bit quiet = 1'b1;
    rand_delays(300, 400);
    pulse_start();
    wait_rst_low(0, ok);
    repeat (5) tick();
    do_abort();
    rand_delays(1, 50);
    pulse_start();
    wait_rst_low(0, ok);
    wait_valid(0, ok);
    do_abort();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (round_done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL abort_quiet: round_done/busy/res_valid not all 0 after abort, want 0");
    end
    pulse_start();
    wait_rst_low(0, ok);
    wait_valid(0, ok);
    accept(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, ch_sel} !== {1'b1, 2'd1}) begin
      errors++; $display("FAIL start_ignored: busy=%b ch_sel=%0d want 1 1", busy, ch_sel);
    end
    wait_rst_low(1, ok);
    do_abort();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, meter_rst} !== 2'b01) begin
      errors++; $display("FAIL start_with_abort: busy=%b meter_rst=%b want 0 1", busy, meter_rst);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    rand_delays(300, 400);
    pulse_start();
    wait_rst_low(0, ok);
    repeat (3) tick();
    #20 rst = 1'b1;
    #5;
    checks++;
    if ({meter_rst, ch_sel, res_valid, res_ch, res_duty, res_status, busy, round_done} !==
        {1'b1, 2'b00, 1'b0, 2'b00, 16'd0, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: meter_rst=%b ch_sel=%0d res_valid=%b res_ch=%0d duty=%0d status=%b busy=%b round_done=%b want 1 0 0 0 0 00 0 0",
               meter_rst, ch_sel, res_valid, res_ch, res_duty, res_status, busy, round_done);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, meter_rst} !== 2'b01) begin
      errors++; $display("FAIL idle_after_async_reset: busy=%b meter_rst=%b want 0 1", busy, meter_rst);
    end
    rand_delays(1, 50);
    do_round(NUM_CH, -1, 0);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 16'd5000, 10, 1'b0);
    test_reset();
    test_basic();
    test_range();
    test_timeout();
    test_backpressure();
    test_entry_high();
    test_cont_wrap();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
